// File: rtl/clock_ui_controller.sv
// Button-driven time/alarm setting sequencer and alarm ring/snooze controller
// for the 12-hour timekeeper. Everything runs on the 1 Hz clock_sec domain.
//
// UI state | meaning
// ---------+------------------------------------------
// RUN    0 | normal display; inc toggles alarm arm
// T_HOUR 1 | editing time hour
// T_MIN  2 | editing time minute
// T_AMPM 3 | editing time meridiem; ok loads timekeeper
// A_HOUR 4 | editing alarm hour
// A_MIN  5 | editing alarm minute
// A_AMPM 6 | editing alarm meridiem; ok commits alarm
//
// Alarm state | meaning
// ------------+------------------------------------------
// IDLE        | waiting for hh:mm:00 match while armed
// RINGING     | sounding; owns all button presses
// SNOOZED     | silent countdown back to RINGING
module clock_ui_controller #(
  parameter int unsigned TIMEOUT    = 30,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_MAX   = 60
) (
  input  logic       clock_sec,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic       cur_am_pm,
  output logic       set_time,
  output logic [3:0] set_hour,
  output logic [5:0] set_minute,
  output logic       set_am_pm,
  output logic [3:0] alarm_hour,
  output logic [5:0] alarm_minute,
  output logic       alarm_am_pm,
  output logic       alarm_enable,
  output logic       alarm_ringing,
  output logic       snoozed,
  output logic [2:0] mode_state
);

  typedef enum logic [2:0] {
    UI_RUN    = 3'd0,
    UI_T_HOUR = 3'd1,
    UI_T_MIN  = 3'd2,
    UI_T_AMPM = 3'd3,
    UI_A_HOUR = 3'd4,
    UI_A_MIN  = 3'd5,
    UI_A_AMPM = 3'd6
  } ui_state_t;

  typedef enum logic [1:0] {
    AL_IDLE    = 2'd0,
    AL_RINGING = 2'd1,
    AL_SNOOZED = 2'd2
  } al_state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic [15:0] SNOOZE_C   = 16'(SNOOZE_SEC);
  localparam logic [15:0] RING_C     = 16'(RING_MAX);

  ui_state_t   ui_q, ui_d;
  al_state_t   al_q, al_d;
  logic [2:0]  prev_q, prev_d;  // {mode, ok, inc} previous samples
  logic [3:0]  buf_hour_q, buf_hour_d;
  logic [5:0]  buf_min_q, buf_min_d;
  logic        buf_ampm_q, buf_ampm_d;
  logic        set_time_q, set_time_d;
  logic [3:0]  set_hour_q, set_hour_d;
  logic [5:0]  set_min_q, set_min_d;
  logic        set_ampm_q, set_ampm_d;
  logic [3:0]  al_hour_q, al_hour_d;
  logic [5:0]  al_min_q, al_min_d;
  logic        al_ampm_q, al_ampm_d;
  logic        al_en_q, al_en_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] ring_q, ring_d;
  logic [15:0] snz_q, snz_d;

  logic raw_mode, raw_ok, raw_inc, any_press;
  logic p_mode, p_ok, p_inc;
  logic ui_mode, ui_ok, ui_inc;
  logic ringing, in_time, in_alarm, alarm_commit, match;

  // Edge detect, mode > ok > inc arbitration, and alarm ownership of presses.
  always_comb begin
    prev_d    = {btn_mode, btn_ok, btn_inc};
    raw_mode  = btn_mode & ~prev_q[2];
    raw_ok    = btn_ok & ~prev_q[1];
    raw_inc   = btn_inc & ~prev_q[0];
    any_press = raw_mode | raw_ok | raw_inc;
    p_mode    = raw_mode;
    p_ok      = raw_ok & ~raw_mode;
    p_inc     = raw_inc & ~raw_ok & ~raw_mode;
    ringing   = (al_q == AL_RINGING);
    ui_mode   = p_mode & ~ringing;
    ui_ok     = p_ok & ~ringing;
    ui_inc    = p_inc & ~ringing;
    in_time   = ui_q inside {UI_T_HOUR, UI_T_MIN, UI_T_AMPM};
    in_alarm  = ui_q inside {UI_A_HOUR, UI_A_MIN, UI_A_AMPM};
  end

  // UI FSM: edit buffer, time load strobe, alarm registers and edit timeout.
  always_comb begin
    ui_d         = ui_q;
    buf_hour_d   = buf_hour_q;
    buf_min_d    = buf_min_q;
    buf_ampm_d   = buf_ampm_q;
    set_time_d   = 1'b0;
    set_hour_d   = set_hour_q;
    set_min_d    = set_min_q;
    set_ampm_d   = set_ampm_q;
    al_hour_d    = al_hour_q;
    al_min_d     = al_min_q;
    al_ampm_d    = al_ampm_q;
    al_en_d      = al_en_q;
    alarm_commit = 1'b0;
    idle_d       = (any_press || ui_q == UI_RUN) ? 16'd0 : idle_q + 16'd1;

    if (ui_q == UI_RUN) begin
      if (ui_mode) begin
        ui_d       = UI_T_HOUR;
        buf_hour_d = cur_hours;
        buf_min_d  = cur_minutes;
        buf_ampm_d = cur_am_pm;
      end else if (ui_inc) begin
        al_en_d = ~al_en_q;
      end
    end else if (ui_mode) begin
      if (in_time) begin
        ui_d       = UI_A_HOUR;
        buf_hour_d = al_hour_q;
        buf_min_d  = al_min_q;
        buf_ampm_d = al_ampm_q;
      end else begin
        ui_d = UI_RUN;
      end
    end else if (ui_ok) begin
      case (ui_q)
        UI_T_HOUR: ui_d = UI_T_MIN;
        UI_T_MIN:  ui_d = UI_T_AMPM;
        UI_T_AMPM: begin
          set_time_d = 1'b1;
          set_hour_d = buf_hour_q;
          set_min_d  = buf_min_q;
          set_ampm_d = buf_ampm_q;
          ui_d       = UI_A_HOUR;
          buf_hour_d = al_hour_q;
          buf_min_d  = al_min_q;
          buf_ampm_d = al_ampm_q;
        end
        UI_A_HOUR: ui_d = UI_A_MIN;
        UI_A_MIN:  ui_d = UI_A_AMPM;
        UI_A_AMPM: begin
          al_hour_d    = buf_hour_q;
          al_min_d     = buf_min_q;
          al_ampm_d    = buf_ampm_q;
          al_en_d      = 1'b1;
          alarm_commit = 1'b1;
          ui_d         = UI_RUN;
        end
        default:   ui_d = UI_RUN;
      endcase
    end else if (ui_inc) begin
      if (ui_q inside {UI_T_HOUR, UI_A_HOUR}) begin
        buf_hour_d = (buf_hour_q == 4'd12) ? 4'd1 : buf_hour_q + 4'd1;
      end else if (ui_q inside {UI_T_MIN, UI_A_MIN}) begin
        buf_min_d = (buf_min_q == 6'd59) ? 6'd0 : buf_min_q + 6'd1;
      end else if (ui_q inside {UI_T_AMPM, UI_A_AMPM}) begin
        buf_ampm_d = ~buf_ampm_q;
      end else begin
        ui_d = UI_RUN;
      end
    end else if (!(in_time || in_alarm) || idle_q >= TIMEOUT_M1) begin
      // Abandon the edit: nothing is committed and no load strobe is issued.
      ui_d = UI_RUN;
    end
  end

  // Alarm FSM: trigger on hh:mm:00 match, ring/snooze countdowns, forced idle.
  always_comb begin
    al_d   = al_q;
    ring_d = ring_q;
    snz_d  = snz_q;
    match  = al_en_q && (cur_hours == al_hour_q) && (cur_minutes == al_min_q) &&
             (cur_am_pm == al_ampm_q) && (cur_seconds == 6'd0);
    case (al_q)
      AL_IDLE: begin
        if (match) begin
          al_d   = AL_RINGING;
          ring_d = RING_C;
        end
      end
      AL_RINGING: begin
        if (p_mode || p_ok) begin
          al_d = AL_IDLE;
        end else if (p_inc) begin
          al_d  = AL_SNOOZED;
          snz_d = SNOOZE_C;
        end else begin
          ring_d = ring_q - 16'd1;
          if (ring_q <= 16'd1) begin
            ring_d = 16'd0;
            al_d   = AL_IDLE;
          end
        end
      end
      AL_SNOOZED: begin
        snz_d = snz_q - 16'd1;
        if (snz_q <= 16'd1) begin
          snz_d  = 16'd0;
          ring_d = RING_C;
          al_d   = AL_RINGING;
        end
      end
      default: al_d = AL_IDLE;
    endcase
    if ((al_en_q && !al_en_d) || alarm_commit) begin
      al_d = AL_IDLE;
    end
  end

  // State and datapath registers; button history resets high so held buttons are ignored.
  always_ff @(posedge clock_sec or posedge reset) begin
    if (reset) begin
      ui_q       <= UI_RUN;
      al_q       <= AL_IDLE;
      prev_q     <= 3'b111;
      buf_hour_q <= 4'd12;
      buf_min_q  <= 6'd0;
      buf_ampm_q <= 1'b0;
      set_time_q <= 1'b0;
      set_hour_q <= 4'd12;
      set_min_q  <= 6'd0;
      set_ampm_q <= 1'b0;
      al_hour_q  <= 4'd12;
      al_min_q   <= 6'd0;
      al_ampm_q  <= 1'b0;
      al_en_q    <= 1'b0;
      idle_q     <= 16'd0;
      ring_q     <= 16'd0;
      snz_q      <= 16'd0;
    end else begin
      ui_q       <= ui_d;
      al_q       <= al_d;
      prev_q     <= prev_d;
      buf_hour_q <= buf_hour_d;
      buf_min_q  <= buf_min_d;
      buf_ampm_q <= buf_ampm_d;
      set_time_q <= set_time_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_ampm_q <= set_ampm_d;
      al_hour_q  <= al_hour_d;
      al_min_q   <= al_min_d;
      al_ampm_q  <= al_ampm_d;
      al_en_q    <= al_en_d;
      idle_q     <= idle_d;
      ring_q     <= ring_d;
      snz_q      <= snz_d;
    end
  end

  assign set_time      = set_time_q;
  assign set_hour      = set_hour_q;
  assign set_minute    = set_min_q;
  assign set_am_pm     = set_ampm_q;
  assign alarm_hour    = al_hour_q;
  assign alarm_minute  = al_min_q;
  assign alarm_am_pm   = al_ampm_q;
  assign alarm_enable  = al_en_q;
  assign alarm_ringing = (al_q == AL_RINGING);
  assign snoozed       = (al_q == AL_SNOOZED);
  assign mode_state    = ui_q;

endmodule

// File: tb/tb_clock_ui_controller.sv
// Scoreboard bench for clock_ui_controller: stimulus pushes expected output
// events (load strobes, ring/snooze edges with their cycle), a negedge monitor
// pops and compares them as the DUT produces them.
module tb_clock_ui_controller;

  logic       clock_sec = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_ok;
  logic [3:0] cur_hours;
  logic [5:0] cur_minutes, cur_seconds;
  logic       cur_am_pm;
  logic       set_time, set_am_pm, alarm_am_pm, alarm_enable, alarm_ringing, snoozed;
  logic [3:0] set_hour, alarm_hour;
  logic [5:0] set_minute, alarm_minute;
  logic [2:0] mode_state;

  clock_ui_controller #(.TIMEOUT(30), .SNOOZE_SEC(300), .RING_MAX(60)) dut (
    .clock_sec(clock_sec), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ok(btn_ok),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .cur_seconds(cur_seconds), .cur_am_pm(cur_am_pm),
    .set_time(set_time), .set_hour(set_hour), .set_minute(set_minute),
    .set_am_pm(set_am_pm), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
    .alarm_am_pm(alarm_am_pm), .alarm_enable(alarm_enable),
    .alarm_ringing(alarm_ringing), .snoozed(snoozed), .mode_state(mode_state)
  );

  always #5 clock_sec = ~clock_sec;

  int cyc = 0;
  always @(posedge clock_sec) cyc <= cyc + 1;

  // Event kinds: 0 load strobe, 1 ring rise, 2 ring fall, 3 snooze rise, 4 snooze fall
  typedef struct {
    int kind;
    int data;
    int at;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  logic ring_prev = 1'b0;
  logic snz_prev  = 1'b0;

  function automatic int pack(input int h, input int m, input int a);
    return (h << 7) | (m << 1) | a;
  endfunction

  task automatic expect_ev(input int kind, input int data, input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_event(input int kind, input int data);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%0d cyc=%0d expected none",
               kind, data, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.data != data || e.at != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d data=%0d cyc=%0d expected kind=%0d data=%0d cyc=%0d",
                 kind, data, cyc, e.kind, e.data, e.at);
      end
    end
  endtask

  // Monitor: sample away from the rising edge and match DUT events to the scoreboard.
  always @(negedge clock_sec) begin
    if (!reset) begin
      if (set_time) mon_event(0, int'({set_hour, set_minute, set_am_pm}));
      if (alarm_ringing != ring_prev) mon_event(alarm_ringing ? 1 : 2, 0);
      if (snoozed != snz_prev) mon_event(snoozed ? 3 : 4, 0);
    end
    ring_prev <= alarm_ringing;
    snz_prev  <= snoozed;
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock_sec);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // which: 0 mode, 1 ok, 2 inc, 3 mode+inc on the same edge
  task automatic press(input int which);
    case (which)
      0: btn_mode = 1'b1;
      1: btn_ok   = 1'b1;
      2: btn_inc  = 1'b1;
      default: begin
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
      end
    endcase
    step();
    btn_mode = 1'b0;
    btn_ok   = 1'b0;
    btn_inc  = 1'b0;
    step();
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  task automatic set_cur(input int h, input int m, input int s, input int a);
    cur_hours   = 4'(h);
    cur_minutes = 6'(m);
    cur_seconds = 6'(s);
    cur_am_pm   = 1'(a);
  endtask

  int m0, c0, p0;

  initial begin
    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_ok   = 1'b0;
    btn_inc  = 1'b1;  // held through reset: must not count as a press
    set_cur(3, 15, 30, 1);
    step();
    step();
    check("rst_mode_state", mode_state, 0);
    check("rst_set_time", set_time, 0);
    check("rst_set_hour", set_hour, 12);
    check("rst_alarm_time", int'({alarm_hour, alarm_minute, alarm_am_pm}), pack(12, 0, 0));
    check("rst_alarm_enable", alarm_enable, 0);
    check("rst_ringing", alarm_ringing, 0);
    reset = 1'b0;
    step();
    check("held_through_reset", alarm_enable, 0);
    btn_inc = 1'b0;
    step();

    // Time edit from 03:15 pm to 05:18 am
    press(0);
    check("run_to_t_hour", mode_state, 1);
    press_n(2, 2);
    press(1);
    check("t_min", mode_state, 2);
    press_n(2, 3);
    press(1);
    check("t_ampm", mode_state, 3);
    press(2);
    expect_ev(0, pack(5, 18, 0), cyc + 1);
    press(1);
    check("after_time_commit", mode_state, 4);
    check("set_hour_hold", int'({set_hour, set_minute, set_am_pm}), pack(5, 18, 0));

    // Alarm edit from 12:00 am to 06:30 am (12 -> 1 wrap on the way)
    press_n(2, 6);
    press(1);
    press_n(2, 30);
    press(1);
    press(1);
    check("alarm_commit_state", mode_state, 0);
    check("alarm_commit_time", int'({alarm_hour, alarm_minute, alarm_am_pm}), pack(6, 30, 0));
    check("alarm_commit_enable", alarm_enable, 1);

    // Same-edge mode+inc in RUN: only mode acts; then 12->1 and 59->0 wraps
    set_cur(12, 59, 30, 0);
    press(3);
    check("mode_beats_inc_state", mode_state, 1);
    check("mode_beats_inc_enable", alarm_enable, 1);
    press(2);
    press(1);
    press(2);
    press(1);
    expect_ev(0, pack(1, 0, 0), cyc + 1);
    press(1);
    check("wrap_commit_state", mode_state, 4);
    press(0);
    check("alarm_edit_discard", mode_state, 0);
    check("alarm_kept", int'({alarm_hour, alarm_minute, alarm_am_pm}), pack(6, 30, 0));

    // Edit timeout: 30 idle periods in T_HOUR return to RUN without a load
    m0 = cyc + 1;
    press(0);
    wait_until(m0 + 29);
    check("timeout_not_yet", mode_state, 1);
    wait_until(m0 + 30);
    check("timeout_run", mode_state, 0);

    // Alarm match at 06:30:00 am: ring one period later for 60 periods
    set_cur(6, 30, 0, 0);
    c0 = cyc;
    expect_ev(1, 0, c0 + 1);
    expect_ev(2, 0, c0 + 61);
    step();
    cur_seconds = 6'd1;
    wait_until(c0 + 63);
    check("ring_auto_dismiss", alarm_ringing, 0);

    // Ring, snooze with inc held for the whole snooze, ring again, ok dismisses
    cur_seconds = 6'd0;
    expect_ev(1, 0, cyc + 1);
    step();
    cur_seconds = 6'd1;
    step();
    step();
    p0 = cyc + 1;
    expect_ev(2, 0, p0);
    expect_ev(3, 0, p0);
    expect_ev(1, 0, p0 + 300);
    expect_ev(4, 0, p0 + 300);
    btn_inc = 1'b1;
    wait_until(p0 + 309);
    check("held_inc_one_snooze", int'({alarm_ringing, snoozed}), 2);
    btn_inc = 1'b0;
    step();
    expect_ev(2, 0, cyc + 1);
    press(1);
    check("ok_dismiss", alarm_ringing, 0);
    check("ok_dismiss_enable", alarm_enable, 1);

    // Snoozed, then inc in RUN disarms and forces the alarm FSM idle
    cur_seconds = 6'd0;
    expect_ev(1, 0, cyc + 1);
    step();
    cur_seconds = 6'd1;
    p0 = cyc + 1;
    expect_ev(2, 0, p0);
    expect_ev(3, 0, p0);
    press(2);
    check("snoozed_now", snoozed, 1);
    expect_ev(4, 0, cyc + 1);
    press(2);
    check("disarm_enable", alarm_enable, 0);
    check("disarm_snoozed", snoozed, 0);

    // Asynchronous reset in the middle of a T_MIN edit
    press(0);
    press(1);
    check("pre_reset_t_min", mode_state, 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_state", mode_state, 0);
    check("async_rst_set_time", set_time, 0);
    check("async_rst_set_hour", set_hour, 12);
    check("async_rst_alarm", int'({alarm_hour, alarm_minute, alarm_am_pm}), pack(12, 0, 0));
    check("async_rst_enable", alarm_enable, 0);
    step();
    reset = 1'b0;
    step();
    step();

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_ui_controller.md
Name: clock_ui_controller

Overview:
- Button-driven mode and alarm sequencer for the 12-hour digital clock timekeeper.
- Walks the user through setting the time and the alarm with three buttons.
- Issues a one-period set_time load to the timekeeper and owns the alarm registers.
- Runs the alarm ring/snooze/dismiss state machine, all on the 1 Hz clock_sec domain.

Parameters:
- TIMEOUT, 30, idle periods in an edit state before abandoning the edit (1..65535).
- SNOOZE_SEC, 300, snooze length in periods (1..65535).
- RING_MAX, 60, periods the alarm rings before auto-dismiss (1..65535).

Ports:
- clock_sec  in  1  1 Hz clock, rising edge.
- reset  in  1  asynchronous, active-high.
- btn_mode  in  1  mode button, level, already debounced.
- btn_inc  in  1  increment/snooze button, level.
- btn_ok  in  1  confirm/dismiss button, level.
- cur_hours  in  4  timekeeper hours, 1..12.
- cur_minutes  in  6  timekeeper minutes.
- cur_seconds  in  6  timekeeper seconds.
- cur_am_pm  in  1  timekeeper meridiem, 1 = pm.
- set_time  out  1  load strobe to the timekeeper.
- set_hour  out  4  time value to load.
- set_minute  out  6  time value to load.
- set_am_pm  out  1  time value to load.
- alarm_hour  out  4  committed alarm time.
- alarm_minute  out  6  committed alarm time.
- alarm_am_pm  out  1  committed alarm time.
- alarm_enable  out  1  alarm armed.
- alarm_ringing  out  1  alarm sounding.
- snoozed  out  1  snooze in progress.
- mode_state  out  3  current UI state encoding.

Behaviour:
- Reset (async): UI state RUN = 0; edit buffer 12:00 am; set_time 0; set_hour 12; set_minute 0; set_am_pm 0; alarm 12:00 am; alarm_enable 0; alarm FSM IDLE; alarm_ringing 0; snoozed 0; all counters 0.
- Press detection: a press is btn high at a rising edge with the registered previous sample low. A held button counts once. The previous-sample registers reset to 1, so a button held through reset is not a press.
- Button priority on the same edge: mode > ok > inc. Only the winner acts.
- While the alarm FSM is RINGING, all presses are consumed by the alarm FSM; the UI FSM sees none.
- UI states and encodings:
  - RUN = 0
  - T_HOUR = 1, T_MIN = 2, T_AMPM = 3 (time edit)
  - A_HOUR = 4, A_MIN = 5, A_AMPM = 6 (alarm edit)
- RUN transitions:
  - mode: go to T_HOUR and load the edit buffer from cur_hours/cur_minutes/cur_am_pm.
  - inc: toggle alarm_enable.
  - ok: no action.
- Edit-state actions:
  - inc in *_HOUR: buffer hour 12 -> 1, otherwise +1.
  - inc in *_MIN: buffer minute 59 -> 0, otherwise +1.
  - inc in *_AMPM: toggle the buffer meridiem.
  - ok: advance HOUR -> MIN -> AMPM.
- ok in T_AMPM (time commit):
  - Copy the buffer to set_hour/minute/am_pm and assert set_time.
  - Load the buffer from the alarm registers; go to A_HOUR.
- mode in any T_* state: discard the edit, load the buffer from the alarm registers, go to A_HOUR.
- ok in A_AMPM (alarm commit): copy the buffer to the alarm registers, set alarm_enable = 1, go to RUN.
- mode in any A_* state: discard the edit, go to RUN.
- set_time timing: registered; high for exactly one clock_sec period, starting the edge after the commit press. set_hour/minute/am_pm are stable from that edge and hold the last committed value afterwards.
- Edit timeout: an idle counter clears on any press and on entering an edit state. When it reaches TIMEOUT in an edit state, return to RUN with no commit and no set_time.
- Alarm states: IDLE, RINGING, SNOOZED.
- Alarm trigger: at an edge, from IDLE, when alarm_enable = 1, cur_hours/minutes/am_pm equal the alarm registers, and cur_seconds == 0. Ringing therefore starts one period after the time reaches hh:mm:00. The trigger is active in every UI state.
- Entering RINGING loads the ring counter with RING_MAX.
- RINGING transitions:
  - ok: go to IDLE.
  - mode: go to IDLE.
  - inc: go to SNOOZED and load the snooze counter with SNOOZE_SEC.
  - Ring counter decrements each period; when it reaches 0, go to IDLE.
- SNOOZED: counter decrements each period; when it reaches 0, go to RINGING with the ring counter reloaded. Buttons act on the UI FSM as normal.
- Forced IDLE: alarm_enable going 0, or an alarm commit, forces the alarm FSM to IDLE at that edge.
- alarm_ringing = (state == RINGING); snoozed = (state == SNOOZED). Both registered.
- Re-trigger: IDLE reached at hh:mm:00 cannot re-trigger until the next matching minute, because cur_seconds == 0 occurs once per minute.

Test Plan:
- Reset mid-edit in T_MIN -> mode_state 0, set_time 0, alarm 12:00 am, alarm_enable 0 immediately, without waiting for an edge.
- From RUN at 03:15 pm, press mode, inc×2, ok, inc×3, ok, inc, ok -> one set_time pulse with 05:18 am, mode_state 4.
- Buffer hour 12 plus one inc -> 1; buffer minute 59 plus one inc -> 0; mode and inc pressed on the same edge -> only mode acts.
- Alarm committed as 06:30 am with timekeeper reaching 06:30:00 am -> alarm_ringing rises one period later and falls after RING_MAX = 60 periods.
- Ringing, then inc press -> snoozed 1 for 300 periods, then ringing again; ok press while ringing -> IDLE; inc held continuously -> one snooze only.
- In T_HOUR, no press for 30 periods -> RUN, no set_time; inc in RUN while SNOOZED -> alarm_enable 0, snoozed 0.
